// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: accepts one opcode per valid/ready handshake and walks
// DECODE/EXEC/MEM/WB, holding memory strobes until acknowledge or timeout.
module multicycle_control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                regWrite,
    output logic                memWrite,
    output logic                memRead,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                busy,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    retired_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [OPCODE_W-1:0] OP_ADD    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB    = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_AND    = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(4);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t              state, nextState;
    logic [OPCODE_W-1:0] opQ;
    logic [WAIT_W-1:0]   waitCnt;
    logic [CNT_W-1:0]    retiredCnt;
    logic                handshake;
    logic                opLegal, opIsLoad, opIsStore, opIsMem;
    logic [ALUOP_W-1:0]  opAlu;

    assign instr_ready = (state == IDLE) && !rst;
    assign handshake   = instr_valid && instr_ready;
    assign busy        = (state != IDLE);
    assign retired_cnt = retiredCnt;

    always_comb begin
        opIsLoad  = (opQ == OP_LOAD);
        opIsStore = (opQ == OP_STORE);
        opIsMem   = opIsLoad || opIsStore;
        opLegal   = (opQ <= OP_STORE);
        case (opQ)
            OP_SUB:  opAlu = ALUOP_W'(1);
            OP_AND:  opAlu = ALUOP_W'(2);
            default: opAlu = '0;  // ADD, and the address add for LOAD/STORE
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opQ        <= '0;
            waitCnt    <= '0;
            retiredCnt <= '0;
        end else begin
            state <= nextState;
            if (handshake)
                opQ <= opcode;
            if (state == EXEC)
                waitCnt <= '0;
            else if (state == MEM)
                waitCnt <= waitCnt + WAIT_W'(1);
            if (instr_done)
                retiredCnt <= retiredCnt + CNT_W'(1);
        end
    end

    always_comb begin
        nextState   = state;
        regWrite    = 1'b0;
        memWrite    = 1'b0;
        memRead     = 1'b0;
        aluOp       = '0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (handshake)
                    nextState = DECODE;
            end
            DECODE: begin
                if (!opLegal) begin
                    illegal   = 1'b1;
                    nextState = IDLE;
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                aluOp     = opAlu;
                nextState = opIsMem ? MEM : WB;
            end
            MEM: begin
                aluOp    = opAlu;
                memRead  = opIsLoad;
                memWrite = opIsStore;
                // an acknowledge in the last allowed cycle still completes the access
                if (mem_ready) begin
                    if (opIsLoad) begin
                        nextState = WB;
                    end else begin
                        instr_done = 1'b1;
                        nextState  = IDLE;
                    end
                end else if (waitCnt == WAIT_LAST) begin
                    mem_timeout = 1'b1;
                    nextState   = IDLE;
                end
            end
            WB: begin
                regWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed + randomized bench for multicycle_control_fsm against a cycle-timeline model.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst, instr_valid, mem_ready;
    logic [5:0] opcode;

    logic        instr_ready, regWrite, memWrite, memRead, busy, instr_done, illegal, mem_timeout;
    logic [1:0]  aluOp;
    logic [15:0] retired_cnt;

    logic        sReady, sRegWrite, sMemWrite, sMemRead, sBusy, sDone, sIllegal, sTimeout;
    logic [1:0]  sAluOp;
    logic [1:0]  sRetired;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .mem_ready(mem_ready), .regWrite(regWrite), .memWrite(memWrite),
        .memRead(memRead), .aluOp(aluOp), .busy(busy), .instr_done(instr_done),
        .illegal(illegal), .mem_timeout(mem_timeout), .retired_cnt(retired_cnt)
    );

    multicycle_control_fsm #(.CNT_W(2)) dutSmall (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(sReady),
        .opcode(opcode), .mem_ready(mem_ready), .regWrite(sRegWrite), .memWrite(sMemWrite),
        .memRead(sMemRead), .aluOp(sAluOp), .busy(sBusy), .instr_done(sDone),
        .illegal(sIllegal), .mem_timeout(sTimeout), .retired_cnt(sRetired)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] retired = '0;
    logic [9:0]  obs;

    // {ready, busy, regWrite, memWrite, memRead, aluOp[1:0], done, illegal, timeout}
    assign obs = {instr_ready, busy, regWrite, memWrite, memRead, aluOp, instr_done, illegal, mem_timeout};

    function automatic logic [9:0] mk(input logic rd, input logic by, input logic rw, input logic mw,
                                      input logic mr, input logic [1:0] al, input logic dn,
                                      input logic il, input logic to);
        return {rd, by, rw, mw, mr, al, dn, il, to};
    endfunction

    task automatic check(input string tag, input logic [9:0] exp, input logic [9:0] mask);
        checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s flags obs=%b exp=%b", tag, obs, exp);
        end
        checks++;
        assert (retired_cnt === retired) else begin
            errors++;
            $error("FAIL %s retired_cnt obs=%0d exp=%0d", tag, retired_cnt, retired);
        end
        checks++;
        assert (sRetired === retired[1:0]) else begin
            errors++;
            $error("FAIL %s small_cnt obs=%0d exp=%0d", tag, sRetired, retired[1:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            opcode      = 6'($urandom);
            mem_ready   = 1'($urandom_range(0, 1));
            #1 check("idle", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);
        end
    endtask

    // One instruction: handshake in cycle 0, then the expected timeline from the opcode
    // and the number of mem_ready-low cycles before acknowledge.
    task automatic doInstr(input logic [5:0] op, input int low, input string name);
        logic       isMem, legal, tmo, dn, lastMem;
        logic [1:0] alu;
        logic [9:0] exp, mask;
        int         m, last;
        isMem = (op == 6'd3) || (op == 6'd4);
        legal = (op <= 6'd4);
        alu   = (op == 6'd1) ? 2'd1 : (op == 6'd2) ? 2'd2 : 2'd0;
        tmo   = isMem && (low >= 15);
        m     = tmo ? 15 : low + 1;
        last  = !legal ? 1 : !isMem ? 3 : (op == 6'd3 && !tmo) ? 3 + m : 3 + m - 1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            instr_valid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode      = (c == 0) ? op : 6'($urandom);
            mem_ready   = (isMem && c >= 3 && c < 3 + m) ? (c - 3 >= low) : 1'($urandom_range(0, 1));
            mask = '1;
            dn   = 1'b0;
            if (c == 0)
                exp = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            else if (!legal)
                exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
            else if (c == 1)
                exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            else if (c == 2)
                exp = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, alu, 1'b0, 1'b0, 1'b0);
            else if (!isMem || c == 3 + m) begin
                dn   = 1'b1;
                exp  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
                mask = 10'b11_1110_0111;  // aluOp is unconstrained in write-back
            end else begin
                lastMem = (c - 3 == m - 1);
                dn  = (op == 6'd4) && lastMem && !tmo;
                exp = mk(1'b0, 1'b1, 1'b0, op == 6'd4, op == 6'd3, 2'd0, dn, 1'b0, tmo && lastMem);
            end
            #1 check($sformatf("%s c%0d", name, c), exp, mask);
            if (dn) retired++;
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        repeat (2) @(posedge clk);
        #2 check("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("rst_release", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);

        doInstr(6'd0, 0, "add");
        idle(1);
        doInstr(6'd3, 2, "load_wait2");
        doInstr(6'd4, 15, "store_timeout");
        idle(1);
        doInstr(6'd4, 14, "store_ready_last");
        doInstr(6'h3F, 0, "illegal3F");
        doInstr(6'd2, 0, "and");

        // reset in the second MEM cycle of a LOAD
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            instr_valid = (c == 0);
            opcode      = (c == 0) ? 6'd3 : 6'($urandom);
            mem_ready   = 1'b0;
            rst         = (c == 4 || c == 5);
            if (c == 5) retired = '0;
            #1;
            case (c)
                0: check("rstmem c0", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);
                3: check("rstmem c3", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), '1);
                4: check("rstmem c4", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), '1);
                5: check("rstmem c5", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);
                6: check("rstmem c6", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), '1);
                default: ;
            endcase
        end

        for (int i = 0; i < 4; i++)
            doInstr(6'd1, 0, $sformatf("sub_wrap%0d", i));
        idle(1);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            int         low;
            op  = ($urandom_range(0, 9) < 6) ? 6'($urandom_range(0, 4)) : 6'($urandom);
            low = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            doInstr(op, low, $sformatf("rand%0d_op%0d_low%0d", i, op, low));
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Accepts one instruction at a time via a valid/ready handshake and sequences DECODE, EXEC, MEM and WB.
- Holds memory strobes until the data memory acknowledges, with a timeout, and counts retired instructions.
- Sits between instruction fetch and the datapath (register file, ALU, data memory).

Parameters:
- OPCODE_W, 6, opcode width (must be >= 3).
- ALUOP_W, 2, ALU operation code width (must be >= 2).
- TIMEOUT, 15, consecutive MEM cycles without mem_ready before abort (>= 1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents an opcode.
- instr_ready  out  1  FSM can accept an opcode.
- opcode  in  OPCODE_W  opcode; sampled only on handshake.
- mem_ready  in  1  data memory acknowledge.
- regWrite  out  1  register-file write enable.
- memWrite  out  1  data memory write strobe.
- memRead  out  1  data memory read strobe.
- aluOp  out  ALUOP_W  ALU operation select.
- busy  out  1  high in any state other than IDLE.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse for an undefined opcode.
- mem_timeout  out  1  one-cycle pulse when a MEM access is aborted.
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Opcode map (zero-extended to OPCODE_W):
  - 0 ADD: aluOp=0.
  - 1 SUB: aluOp=1.
  - 2 AND: aluOp=2.
  - 3 LOAD: aluOp=0 (address add).
  - 4 STORE: aluOp=0.
  - Any other value is illegal.
- Handshake and capture:
  - instr_ready = (state==IDLE) && !rst.
  - A handshake occurs when instr_valid && instr_ready; opcode is latched into op_q on that edge.
  - opcode is ignored outside a handshake.
- States:
  - IDLE: on handshake -> DECODE; else stay.
  - DECODE: illegal op_q -> IDLE with illegal=1 this cycle; else -> EXEC.
  - EXEC: aluOp per map. ADD/SUB/AND -> WB; LOAD/STORE -> MEM; the wait counter is cleared on entry to MEM.
  - MEM: memRead=1 (LOAD) or memWrite=1 (STORE), held every MEM cycle; aluOp is held.
    - mem_ready=1: LOAD -> WB. STORE -> IDLE, with instr_done=1 this cycle.
    - mem_ready=0 and wait count == TIMEOUT-1 (i.e. the TIMEOUT-th low cycle): mem_timeout=1 this cycle, -> IDLE, no retire.
    - Otherwise the wait count increments.
    - mem_ready=1 wins over the timeout in the same cycle.
  - WB: regWrite=1 for exactly one cycle, instr_done=1 -> IDLE.
- Output defaults: aluOp=0 in IDLE and DECODE. regWrite, memRead and memWrite are 0 outside their listed states, including during illegal and timeout exits.
- Output structure: all outputs decode from registered state, op_q and counters only. The only combinational input paths are mem_ready -> instr_done/mem_timeout and rst -> instr_ready.
- Latency (handshake in cycle 0):
  - ALU op: WB, regWrite and instr_done in cycle 3.
  - LOAD, ready at first MEM cycle: memRead in cycle 3, regWrite in cycle 4.
  - STORE, ready at first MEM cycle: memWrite and instr_done in cycle 3.
  - Each mem_ready-low cycle adds 1.
  - Next handshake is possible in the cycle after instr_done, illegal or mem_timeout.
- retired_cnt:
  - Increments by 1 on each instr_done and wraps from 2^CNT_W-1 to 0.
  - Illegal and timeout exits do not count.
- Reset:
  - rst=1 forces on the next edge: state=IDLE, op_q=0, wait count=0, retired_cnt=0.
  - Resulting outputs: all strobes and pulses 0, aluOp=0, busy=0.
  - instr_ready=0 while rst is high and 1 in the first cycle after deassertion.
  - Reset mid-MEM drops the strobe immediately after the edge; no instr_done.
  - rst has priority over every transition.

Test Plan:
- ADD (opcode 0) handshake in cycle 0 -> busy cycles 1-3. aluOp=0 in EXEC. regWrite=1 and instr_done=1 in cycle 3 only. retired_cnt 0->1. instr_ready=1 in cycle 4.
- LOAD (3) with mem_ready low for 2 MEM cycles, then high -> memRead=1 for cycles 3-5. regWrite=1 in cycle 6. retired_cnt +1.
- STORE (4) with mem_ready held low, TIMEOUT=15 -> memWrite=1 for cycles 3-17. mem_timeout=1 in cycle 17. IDLE in cycle 18. regWrite never asserted. retired_cnt unchanged.
- STORE where mem_ready rises in cycle 17 (the 15th MEM cycle) -> instr_done=1 and mem_timeout=0 in cycle 17.
- Opcode 6'h3F -> illegal=1 in cycle 1. No strobes. IDLE and instr_ready=1 in cycle 2.
- rst asserted during LOAD MEM -> after the edge memRead=0, busy=0, retired_cnt=0. instr_ready=1 one cycle after rst falls.
- CNT_W=2: four back-to-back SUBs -> retired_cnt 1,2,3,0.
